hs_xfer_tx: RTL and testbench

// Source-side endpoint of a 4-phase req/ack clock-domain-crossing handshake; runs in clko.

---
 rtl/hs_xfer_pkg.sv | 4 +
 rtl/bit_sync.sv | 18 +
 rtl/hs_xfer_tx.sv | 76 +++++++
 tb/tb_hs_xfer_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_xfer_pkg.sv
// hs_xfer_pkg: shared state type for the 4-phase handshake source endpoint
package hs_xfer_pkg;
  typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_REL} hs_state_t;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: LEN-deep async-reset flop chain bringing a level signal into clko
module bit_sync #(
  parameter int LEN = 3
) (
  input  logic clko,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  if (LEN < 2) begin : g_len_chk
    $error("bit_sync: LEN must be >= 2");
  end
  logic [LEN-1:0] sync_q;
  always_ff @(posedge clko or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[LEN-2:0], d_i};
  assign q_o = sync_q[LEN-1];
endmodule

// File: rtl/hs_xfer_tx.sv
// hs_xfer_tx: source side of a 4-phase req/ack CDC handshake with done pulse
// and sticky per-phase timeout flag.
module hs_xfer_tx
  import hs_xfer_pkg::*;
#(
  parameter int DW      = 8,
  parameter int LEN     = 3,
  parameter int TIMEOUT = 0
) (
  input  logic          clko,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          ack_i,
  output logic          done_o,
  input  logic          err_clr_i,
  output logic          to_err_o
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  hs_state_t state_q, state_d;
  logic req_q, req_d, done_q, done_d, err_q, err_d, ack_s, accept, to_set;
  logic [DW-1:0] data_q, data_d;
  logic [TW-1:0] timer_q, timer_d;
  bit_sync #(.LEN(LEN)) u_ack_sync (
    .clko (clko),
    .rst  (rst),
    .d_i  (ack_i),
    .q_o  (ack_s)
  );
  assign ready_o = (state_q == HS_IDLE) && !ack_s;
  assign accept  = valid_i && ready_o;
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      HS_IDLE: state_d = accept ? HS_REQ : HS_IDLE;
      HS_REQ:  state_d = ack_s ? HS_REL : HS_REQ;
      HS_REL: begin
        state_d = ack_s ? HS_REL : HS_IDLE;
        done_d  = !ack_s;
      end
      default: state_d = HS_IDLE;
    endcase
    req_d   = state_d == HS_REQ;
    data_d  = accept ? data_i : data_q;
    timer_d = (state_d != state_q || state_q == HS_IDLE) ? '0 :
              (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
    // set only on the step into TMAX so a clear can stick while still waiting
    to_set  = (TIMEOUT > 0) && (timer_q != TMAX) && (timer_d == TMAX);
    err_d   = to_set || (err_q && !err_clr_i);
  end
  always_ff @(posedge clko or posedge rst)
    if (rst) begin
      state_q <= HS_IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      timer_q <= timer_d;
    end
  assign req_o    = req_q;
  assign data_o   = data_q;
  assign done_o   = done_q;
  assign to_err_o = err_q;
endmodule

// File: tb/tb_hs_xfer_tx.sv
// tb_hs_xfer_tx: directed and randomized checks of hs_xfer_tx against a
// cycle-table / scoreboard model of the 4-phase handshake.
module tb_hs_xfer_tx;
  localparam int DW = 8, LEN = 3, TMO = 16;
  logic clk = 1'b0;
  logic rst, valid_i, ready_o, req_o, ack_i, done_o, err_clr_i, to_err_o;
  logic [DW-1:0] data_i, data_o;
  logic [DW-1:0] q[$];
  logic [LEN:0] h;
  int total = 0, bad = 0, pcnt = 0;

  hs_xfer_tx #(.DW(DW), .LEN(LEN), .TIMEOUT(TMO)) dut (
    .clko      (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .req_o     (req_o),
    .data_o    (data_o),
    .ack_i     (ack_i),
    .done_o    (done_o),
    .err_clr_i (err_clr_i),
    .to_err_o  (to_err_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0; data_i = '0; ack_i = 1'b0; err_clr_i = 1'b0; pcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // destination peer: follows req_o with ack_i after a countdown
  task automatic peer_step(input bit rnd);
    if (req_o != ack_i) begin
      if (pcnt == 0) begin
        ack_i = req_o;
        pcnt = rnd ? int'($urandom_range(0, 40)) : 0;
      end else pcnt--;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; data_i = 8'hFF; ack_i = 1'b0; err_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    total += 5;
    if (req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", req_o); end
    if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    if (to_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", to_err_o); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    valid_i = 1'b1; data_i = 8'hA5;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      total += 4;
      if (req_o !== (c <= 8)) begin bad++; $display("FAIL single_req c=%0d got=%b exp=%b", c, req_o, c <= 8); end
      if (done_o !== (c == 16)) begin bad++; $display("FAIL single_done c=%0d got=%b exp=%b", c, done_o, c == 16); end
      if (ready_o !== (c >= 16)) begin bad++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, ready_o, c >= 16); end
      if (data_o !== 8'hA5) begin bad++; $display("FAIL single_data c=%0d got=%h exp=a5", c, data_o); end
      if (c == 1) valid_i = 1'b0;
      if (c == 5) ack_i = 1'b1;
      if (c == 12) ack_i = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [3];
    int idx = 0, ndone = 0;
    bit took = 0;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    do_reset();
    q.delete();
    valid_i = 1'b1; data_i = words[0];
    for (int c = 0; c < 400 && ndone < 3; c++) begin
      if (took) begin
        took = 0; idx++;
        if (idx == 3) valid_i = 1'b0; else data_i = words[idx];
      end
      if (done_o) begin
        total++;
        if (q.size() == 0 || data_o !== q[0] || data_o !== words[ndone]) begin
          bad++; $display("FAIL b2b_done_order n=%0d got=%h exp=%h", ndone, data_o, words[ndone]);
        end
        if (q.size() != 0) void'(q.pop_front());
        ndone++;
      end else if (q.size() != 0) begin
        total++;
        if (data_o !== q[0]) begin bad++; $display("FAIL b2b_hold c=%0d got=%h exp=%h", c, data_o, q[0]); end
      end
      if (valid_i && ready_o) begin
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL b2b_early_accept c=%0d outstanding=%0d exp=0", c, q.size()); end
        q.push_back(data_i); took = 1;
      end
      peer_step(0);
      @(negedge clk);
    end
    total++;
    if (ndone != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", ndone); end
  endtask

  task automatic test_timeout();
    bit seen = 0;
    do_reset();
    valid_i = 1'b1; data_i = 8'h5A;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      total += 2;
      if (req_o !== 1'b1) begin bad++; $display("FAIL to_req c=%0d got=%b exp=1", c, req_o); end
      if (to_err_o !== (c >= 17)) begin bad++; $display("FAIL to_set c=%0d got=%b exp=%b", c, to_err_o, c >= 17); end
      if (c == 1) valid_i = 1'b0;
      if (c == 21) err_clr_i = 1'b1;
    end
    @(negedge clk);
    err_clr_i = 1'b0;
    total++;
    if (to_err_o !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", to_err_o); end
    repeat (3) @(negedge clk);
    total += 2;
    if (to_err_o !== 1'b0) begin bad++; $display("FAIL to_stay_clear got=%b exp=0", to_err_o); end
    if (req_o !== 1'b1) begin bad++; $display("FAIL to_req_held got=%b exp=1", req_o); end
    ack_i = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      total += 2;
      if (to_err_o !== (k >= 20)) begin bad++; $display("FAIL to_set_vs_clr k=%0d got=%b exp=%b", k, to_err_o, k >= 20); end
      if (req_o !== (k <= 3)) begin bad++; $display("FAIL to_rel_req k=%0d got=%b exp=%b", k, req_o, k <= 3); end
      err_clr_i = (k == 19);
    end
    ack_i = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = done_o;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL to_done got=0 exp=1 within 10 cycles"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid_i = 1'b1; data_i = 8'h3C;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (req_o !== 1'b1) begin bad++; $display("FAIL mid_req_pre got=%b exp=1", req_o); end
    ack_i = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total += 2;
    if (req_o !== 1'b0) begin bad++; $display("FAIL mid_req_async got=%b exp=0", req_o); end
    if (data_o !== 8'h00) begin bad++; $display("FAIL mid_data_async got=%h exp=00", data_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        total++;
        if (ready_o !== 1'b0) begin bad++; $display("FAIL mid_stale_ready k=%0d got=%b exp=0", k, ready_o); end
      end
    end
    ack_i = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      total++;
      if (ready_o !== (j == 3)) begin bad++; $display("FAIL mid_ready_release j=%0d got=%b exp=%b", j, ready_o, j == 3); end
    end
  endtask

  task automatic test_random();
    int nacc = 0, ndone = 0;
    logic reqp = 1'b0;
    do_reset();
    q.delete();
    h = '0;
    for (int c = 0; c < 90000 && ndone < 1000; c++) begin
      data_i = DW'($urandom);
      valid_i = (nacc < 1000) && ($urandom_range(0, 3) != 0);
      if (done_o) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL rnd_spurious_done c=%0d got=%h exp=none", c, data_o); end
        else begin
          if (data_o !== q[0]) begin bad++; $display("FAIL rnd_order c=%0d got=%h exp=%h", c, data_o, q[0]); end
          void'(q.pop_front());
        end
        ndone++;
      end else if (q.size() != 0) begin
        total++;
        if (data_o !== q[0]) begin bad++; $display("FAIL rnd_hold c=%0d got=%h exp=%h", c, data_o, q[0]); end
      end
      if (req_o && !reqp) begin
        total++;
        if (h[LEN] !== 1'b0) begin bad++; $display("FAIL rnd_req_vs_ack c=%0d ack_s=%b exp=0", c, h[LEN]); end
      end
      reqp = req_o;
      if (valid_i && ready_o) begin
        q.push_back(data_i);
        nacc++;
      end
      peer_step(1);
      h = {h[LEN-1:0], ack_i};
      @(negedge clk);
    end
    total += 2;
    if (ndone != 1000) begin bad++; $display("FAIL rnd_done_count got=%0d exp=1000", ndone); end
    if (nacc != ndone) begin bad++; $display("FAIL rnd_acc_vs_done got=%0d exp=%0d", ndone, nacc); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
